// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Package     : cpu_pkg
// Description : Shared definitions for the control sequencer. Holds the FSM
//               state encoding, the opcode and ALU code constants, the
//               instruction field bit positions and the opcode classes.
//               SINGLE_STEP_EN adds the WAIT state.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  // Instruction field positions: opcode | Ra | Rb | Rc | unused
  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  // Opcodes
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_SHL  = 4;
  localparam int OP_SHR  = 5;
  localparam int OP_SHRA = 6;
  localparam int OP_ROL  = 7;
  localparam int OP_ROR  = 8;
  localparam int OP_NEG  = 9;
  localparam int OP_NOT  = 10;
  localparam int OP_NOP  = 26;
  localparam int OP_HALT = 27;

  // ALU operation codes; identical to opcode[3:0] for the ALU instructions
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHL  = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_ROL  = 4'd7;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_NEG  = 4'd9;
  localparam logic [3:0] ALU_NOT  = 4'd10;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
`ifdef SINGLE_STEP_EN
    ST_HALT = 4'd7,
    ST_WAIT = 4'd8
`else
    ST_HALT = 4'd7
`endif
  } state_e;

  // Opcode classes produced by the decoder
  localparam logic [2:0] CLS_THREE = 3'd0;
  localparam logic [2:0] CLS_TWO   = 3'd1;
  localparam logic [2:0] CLS_NOP   = 3'd2;
  localparam logic [2:0] CLS_HALT  = 3'd3;
  localparam logic [2:0] CLS_UNDEF = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ir_decoder.sv
//------------------------------------------------------------------------------
// Module      : ir_decoder
// Description : Combinational instruction decode. Splits the IR word into
//               one-hot register selects, the ALU code and the opcode class.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ir_decoder
  import cpu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic [31:0]      ir_i,
  output logic [NREGS-1:0] ra_oh_o,
  output logic [NREGS-1:0] rb_oh_o,
  output logic [NREGS-1:0] rc_oh_o,
  output logic [3:0]       alu_o,
  output logic [2:0]       class_o
);

  logic [OPW-1:0] opcode;
  logic [3:0]     ra;
  logic [3:0]     rb;
  logic [3:0]     rc;
  int             op_val;
  logic           unused_ir;

  assign opcode    = ir_i[IR_OP_MSB -: OPW];
  assign ra        = ir_i[IR_RA_MSB:IR_RA_LSB];
  assign rb        = ir_i[IR_RB_MSB:IR_RB_LSB];
  assign rc        = ir_i[IR_RC_MSB:IR_RC_LSB];
  assign op_val    = int'(opcode);
  assign alu_o     = opcode[3:0];
  assign unused_ir = ^ir_i[IR_RC_LSB-1:0];

  // One-hot register selects, one comparator per register
  for (genvar i = 0; i < NREGS; i++) begin : g_onehot
    assign ra_oh_o[i] = ({28'd0, ra} == 32'(i));
    assign rb_oh_o[i] = ({28'd0, rb} == 32'(i));
    assign rc_oh_o[i] = ({28'd0, rc} == 32'(i));
  end

  // Opcode class; anything not recognised is undefined and treated as nop
  always_comb begin
    class_o = CLS_UNDEF;
    if (op_val <= OP_ROR)                          class_o = CLS_THREE;
    else if (op_val == OP_NEG || op_val == OP_NOT) class_o = CLS_TWO;
    else if (op_val == OP_NOP)                     class_o = CLS_NOP;
    else if (op_val == OP_HALT)                    class_o = CLS_HALT;
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// Module      : control_sequencer
// Description : Hardwired control unit. Runs fetch (T0-T2), then executes
//               register-to-register ALU instructions (T3-T5). Strobes are a
//               combinational function of the state and the IR fields.
//               SINGLE_STEP_EN adds the step input and a WAIT state entered
//               at every instruction end.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  input  logic             stop,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             PCin,
  output logic             PCout,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zlowout,
  output logic             Read,
  output logic [3:0]       ALUop,
  output logic             Run
);

  logic [NREGS-1:0] ra_oh;
  logic [NREGS-1:0] rb_oh;
  logic [NREGS-1:0] rc_oh;
  logic [3:0]       alu_code;
  logic [2:0]       op_class;
  state_e           state_q;
  state_e           state_d;
  logic             pcin_first_q;
  logic             stop_pend_q;
  logic             stop_req;
  logic             end_instr;

  ir_decoder #(
    .NREGS (NREGS),
    .OPW   (OPW)
  ) u_ir_decoder (
    .ir_i    (IR),
    .ra_oh_o (ra_oh),
    .rb_oh_o (rb_oh),
    .rc_oh_o (rc_oh),
    .alu_o   (alu_code),
    .class_o (op_class)
  );

  // A stop request seen at any point is held until the instruction ends
  assign stop_req = stop | stop_pend_q;

  // Next-state selection; every instruction end funnels through end_instr
  always_comb begin
    state_d   = state_q;
    end_instr = 1'b0;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (op_class == CLS_THREE || op_class == CLS_TWO) state_d = ST_T4;
        else if (op_class == CLS_HALT)                     state_d = ST_HALT;
        else                                               end_instr = 1'b1;
      end
      ST_T4: begin
        if (op_class == CLS_THREE) state_d = ST_T5;
        else                       end_instr = 1'b1;
      end
      ST_T5:   end_instr = 1'b1;
      ST_HALT: state_d = ST_HALT;
`ifdef SINGLE_STEP_EN
      ST_WAIT: begin
        if (stop_req)  state_d = ST_HALT;
        else if (step) state_d = ST_T0;
      end
`endif
      default: state_d = ST_RST;
    endcase
    if (end_instr) begin
`ifdef SINGLE_STEP_EN
      state_d = stop_req ? ST_HALT : ST_WAIT;
`else
      state_d = stop_req ? ST_HALT : ST_T0;
`endif
    end
  end

  // State register plus the first-T1 marker and the pending stop flag
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= ST_RST;
      pcin_first_q <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcin_first_q <= (state_d == ST_T1) && (state_q != ST_T1);
      stop_pend_q  <= stop_req && (state_d != ST_HALT);
    end
  end

  // Moore strobe decode from state and IR fields; only one bus driver per state
  always_comb begin
    Rin     = '0;
    Rout    = '0;
    PCin    = 1'b0;
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zlowin  = 1'b0;
    Zlowout = 1'b0;
    Read    = 1'b0;
    ALUop   = 4'd0;
    Run     = (state_q != ST_RST) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = pcin_first_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (op_class == CLS_THREE) begin
          Rout = rb_oh;
          Yin  = 1'b1;
        end else if (op_class == CLS_TWO) begin
          Rout   = rb_oh;
          ALUop  = alu_code;
          Zlowin = 1'b1;
        end
      end
      ST_T4: begin
        if (op_class == CLS_THREE) begin
          Rout   = rc_oh;
          ALUop  = alu_code;
          Zlowin = 1'b1;
        end else if (op_class == CLS_TWO) begin
          Zlowout = 1'b1;
          Rin     = ra_oh;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        Rin     = ra_oh;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. Expected strobe
//               vectors are built per instruction from the cycle rules of
//               each instruction class; SINGLE_STEP_EN adds WAIT/step cycles.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  localparam logic [10:0] S_PCIN  = 11'h400;
  localparam logic [10:0] S_PCOUT = 11'h200;
  localparam logic [10:0] S_INCPC = 11'h100;
  localparam logic [10:0] S_MARIN = 11'h080;
  localparam logic [10:0] S_MDRIN = 11'h040;
  localparam logic [10:0] S_MDROUT= 11'h020;
  localparam logic [10:0] S_IRIN  = 11'h010;
  localparam logic [10:0] S_YIN   = 11'h008;
  localparam logic [10:0] S_ZIN   = 11'h004;
  localparam logic [10:0] S_ZOUT  = 11'h002;
  localparam logic [10:0] S_READ  = 11'h001;

  typedef struct {
    logic [47:0] exp;
    logic [31:0] ir;
    logic        mr;
    logic        stp;
    logic        stepv;
    logic [63:0] tag;
  } cyc_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR = 32'd0;
  logic        mem_ready = 1'b0;
  logic        stop = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout, Read;
  logic [3:0]  ALUop;
  logic        Run;
  logic [47:0] obs;

  int   total = 0;
  int   bad   = 0;
  cyc_t q[$];

  always #5 clock = ~clock;

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clock     (clock),
    .clear     (clear),
    .IR        (IR),
    .mem_ready (mem_ready),
    .stop      (stop),
`ifdef SINGLE_STEP_EN
    .step      (step),
`endif
    .Rin       (Rin),
    .Rout      (Rout),
    .PCin      (PCin),
    .PCout     (PCout),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zlowin    (Zlowin),
    .Zlowout   (Zlowout),
    .Read      (Read),
    .ALUop     (ALUop),
    .Run       (Run)
  );

  assign obs = {Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin,
                Yin, Zlowin, Zlowout, Read, ALUop, Run};

  function automatic logic [47:0] v(logic [15:0] rin, logic [15:0] rout,
                                    logic [10:0] s, logic [3:0] alu, logic run);
    return {rin, rout, s, alu, run};
  endfunction

  function automatic cyc_t mk(logic [47:0] e, logic [31:0] ir, logic mr,
                              logic stp, logic stepv, logic [63:0] tag);
    cyc_t c;
    c.exp = e; c.ir = ir; c.mr = mr; c.stp = stp; c.stepv = stepv; c.tag = tag;
    return c;
  endfunction

  // Expected cycles of one instruction; keep>0 truncates, gap adds WAIT/step
  function automatic void add_instr(logic [31:0] ir, int stalls, int keep,
                                    bit stop_t4, bit gap);
    cyc_t        l[$];
    int          op  = int'(ir[31:27]);
    logic [15:0] a   = 16'd1 << ir[26:23];
    logic [15:0] b   = 16'd1 << ir[22:19];
    logic [15:0] c   = 16'd1 << ir[18:15];
    logic [3:0]  alu = ir[30:27];
    l.push_back(mk(v(0, 0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 1), ir,
                   1'($urandom_range(0, 1)), 0, 0, "T0"));
    for (int k = 0; k <= stalls; k++)
      l.push_back(mk(v(0, 0, (k == 0 ? S_PCIN : 11'd0) | S_ZOUT | S_READ | S_MDRIN, 0, 1),
                     ir, (k == stalls), 0, 0, "T1"));
    l.push_back(mk(v(0, 0, S_MDROUT | S_IRIN, 0, 1), ir, 1'($urandom_range(0, 1)), 0, 0, "T2"));
    if (op <= 8) begin
      l.push_back(mk(v(0, b, S_YIN, 0, 1), ir, 1'($urandom_range(0, 1)), 0, 0, "T3"));
      l.push_back(mk(v(0, c, S_ZIN, alu, 1), ir, 1'($urandom_range(0, 1)), stop_t4, 0, "T4"));
      l.push_back(mk(v(a, 0, S_ZOUT, 0, 1), ir, 1'($urandom_range(0, 1)), 0, 0, "T5"));
    end else if (op == 9 || op == 10) begin
      l.push_back(mk(v(0, b, S_ZIN, alu, 1), ir, 1'($urandom_range(0, 1)), 0, 0, "T3"));
      l.push_back(mk(v(a, 0, S_ZOUT, 0, 1), ir, 1'($urandom_range(0, 1)), stop_t4, 0, "T4"));
    end else begin
      l.push_back(mk(v(0, 0, 0, 0, 1), ir, 1'($urandom_range(0, 1)), 0, 0, "T3"));
    end
    if (keep == 0) keep = l.size();
    for (int i = 0; i < keep; i++) q.push_back(l[i]);
`ifdef SINGLE_STEP_EN
    if (gap)
      for (int k = 0; k < 6; k++)
        q.push_back(mk(v(0, 0, 0, 0, 1), ir, 1'($urandom_range(0, 1)), 0, (k == 5), "WAIT"));
`else
    if (gap) begin end
`endif
  endfunction

  function automatic void add_halted(int n);
    for (int k = 0; k < n; k++)
      q.push_back(mk(v(0, 0, 0, 0, 0), $urandom, 1'($urandom_range(0, 1)), 0, 0, "HALT"));
  endfunction

  task automatic check(logic [47:0] e, logic [63:0] tag);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %0s obs=%h exp=%h", tag, obs, e);
    end
  endtask

  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clock);
      #1;
      IR        = c.ir;
      mem_ready = c.mr;
      stop      = c.stp;
`ifdef SINGLE_STEP_EN
      step      = c.stepv;
`endif
      @(negedge clock);
      check(c.exp, c.tag);
    end
    stop = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 clear = 1'b0;
    IR = $urandom;
    @(negedge clock);
    check(48'd0, "rst");
    @(negedge clock);
    check(48'd0, "rst_hold");
    #1 clear = 1'b1;
  endtask

  function automatic logic [31:0] rand_ir();
    int          sel = int'($urandom_range(0, 13));
    logic [4:0]  op;
    logic [26:0] rest = 27'($urandom);
    if (sel <= 10)      op = 5'(sel);
    else if (sel == 11) op = 5'd26;
    else if (sel == 12) op = 5'($urandom_range(11, 25));
    else                op = 5'($urandom_range(28, 31));
    return {op, rest};
  endfunction

  initial begin
    // Reset state
    #1;
    do_reset();

    // Directed: shr R7,R0,R4 and neg R2,R5, each from fresh fetch
    add_instr(32'h2B820000, 0, 0, 0, 1);
    add_instr(32'h49280000, 0, 0, 0, 1);
    // add R1,R2,R3 with mem_ready low for 3 cycles in T1
    add_instr(32'h00918000, 3, 0, 0, 1);
    // nop and an undefined opcode
    add_instr(32'hD0000000, 0, 0, 0, 1);
    add_instr(32'h78000000, 1, 0, 0, 1);
    run_queue();

    // Randomized instruction stream
    for (int n = 0; n < 40; n++)
      add_instr(rand_ir(), int'($urandom_range(0, 3)), 0, 0, 1);
    run_queue();

    // clear falls during T4 of an add: strobes drop immediately
    add_instr(32'h00918000, 0, 5, 0, 0);
    run_queue();
    #1 clear = 1'b0;
    #1 check(48'd0, "clr_async");
    @(negedge clock);
    check(48'd0, "clr_hold");
    #1 clear = 1'b1;
    add_instr(32'h3B918000, 2, 0, 0, 1);
    run_queue();

    // stop pulsed during T4 of an add: add completes, then HALT
    add_instr(32'h00918000, 0, 0, 1, 0);
    add_halted(10);
    run_queue();

    // halt instruction
    do_reset();
    add_instr(32'hD8000000, 1, 0, 0, 0);
    add_halted(12);
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardware control unit that drives the existing datapath's control strobes.
- Runs the fetch cycles T0–T2, then decodes the IR word fed back from the datapath and runs the execute cycles for register-to-register ALU instructions.
- Sits beside the datapath. Outputs connect one-to-one to the datapath's control inputs; this is the counterpart of the hand-written state machines in our unit benches.

Parameters:
- NREGS, 16, number of general registers; sets the Rin/Rout width.
- OPW, 5, opcode field width (IR[31:27]).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents from the datapath; valid from T3 onward.
- mem_ready  in  1  memory read complete; sampled in T1.
- stop  in  1  request halt at the next instruction boundary.
- Rin  out  NREGS  one-hot register load.
- Rout  out  NREGS  one-hot register bus drive.
- PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout  out  1 each  datapath strobes.
- Read  out  1  memory read.
- ALUop  out  4  ALU operation.
- Run  out  1  high unless halted.

Behaviour:
- Field decode:
  - opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - Rin/Rout are one-hot decodes of these fields.
- Outputs are a Moore function of state plus IR fields (combinational). Every strobe defaults to 0 and ALUop defaults to 0 in every state not listed below.
- States: RST, T0, T1, T2, T3, T4, T5, HALT.
- Reset: clear low → immediately state=RST, all strobes 0, ALUop=0, Run=0. First rising edge after clear goes high: RST→T0, Run=1.
- Per-state strobes:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
    - While mem_ready=0, stay in T1 with Read and MDRin held.
    - PCin is asserted only in the first T1 cycle, so PC is loaded once.
  - T2: MDRout, IRin.
- Decode in T3 by opcode class.
  - Three-register class (opcodes 0–8: add, sub, and, or, shl, shr, shra, rol, ror), 6 cycles:
    - T3: Rout[Rb], Yin.
    - T4: Rout[Rc], ALUop=opcode[3:0], Zlowin.
    - T5: Zlowout, Rin[Ra].
    - T5→T0.
  - Two-register class (opcodes 9 neg, 10 not), 5 cycles:
    - T3: Rout[Rb], ALUop=opcode[3:0], Zlowin.
    - T4: Zlowout, Rin[Ra].
    - T4→T0.
  - nop (opcode 26) and any undefined opcode: T3 asserts nothing, T3→T0.
  - halt (opcode 27): T3→HALT.
- HALT: all strobes 0, Run=0. Only reset leaves HALT.
- stop: sampled at every instruction end (transition into T0). If stop=1, go to HALT instead of T0. stop asserted mid-instruction takes effect at the end of that instruction.
- Reset mid-instruction aborts the instruction immediately. No partial Rin may be asserted after clear falls.
- At most one Rin bit and one Rout bit are ever set. The Rout and Zlowout/MDRout/PCout bus drivers are mutually exclusive in every state.
- Latency: 6 cycles per 3-register instruction with mem_ready=1; each low mem_ready cycle adds 1.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined:
  - Adds input step.
  - At every instruction end, the FSM enters state WAIT instead of T0. Run stays 1 and all strobes are 0.
  - The rising edge where step=1 moves WAIT→T0.
  - stop sampled while in WAIT moves WAIT→HALT.
- When undefined: no step port, no WAIT state; behaviour exactly as above.

Decomposition:
- Shared package cpu_pkg holds:
  - State enum.
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SHL=4, OP_SHR=5, OP_SHRA=6, OP_ROL=7, OP_ROR=8, OP_NEG=9, OP_NOT=10, OP_NOP=26, OP_HALT=27.
  - ALU codes equal to opcode[3:0] for opcodes 0–10 (ALU_SHR=5, as the ALU already decodes).
  - IR field bit positions.
- One sub-module: ir_decoder, combinational. Produces Ra/Rb/Rc one-hot vectors and the opcode class: three-register / two-register / nop / halt / undefined.

Test Plan:
- shr R7,R0,R4 (IR=0x2B820000) on the full datapath with R0=0x34, R4=0x2, mem_ready=1 → R7=0x0000000D after T5. In T4: ALUop=5 and Rout=0x0010. In T5: Rin=0x0080.
- neg R2,R5 (IR=0x49280000) with R5=0x00000001 → only 5 cycles T0–T4, R2=0xFFFFFFFF, next cycle is T0.
- mem_ready low for 3 cycles in T1 → T1 lasts 4 cycles, PCin pulses exactly once, Read stays high throughout, PC incremented once.
- halt (IR=0xD8000000) → HALT after T3, Run=0, all strobes 0 for 10+ cycles. stop=1 asserted during T4 of an add → add completes, then HALT.
- clear driven low during T4 of add → strobes 0 within the same cycle, destination register unchanged. After release: RST→T0.
- With SINGLE_STEP_EN: FSM waits in WAIT for 5 cycles with no strobes. One step pulse → exactly one instruction executes, then WAIT again.
